// File: rtl/biquad_pkg.sv
// Shared widths, coefficient index encodings, FSM states and saturation helpers
// for the biquad cascade scheduler.
package biquad_pkg;

    localparam int COEF_W = 18;
    localparam int DATA_W = 18;

    localparam logic [2:0] IDX_B1    = 3'd0;
    localparam logic [2:0] IDX_B2    = 3'd1;
    localparam logic [2:0] IDX_B3    = 3'd2;
    localparam logic [2:0] IDX_A2    = 3'd3;
    localparam logic [2:0] IDX_A3    = 3'd4;
    localparam logic [2:0] IDX_SCALE = 3'd5;

    localparam logic [COEF_W-1:0] ONE_Q216 = 18'h10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAP  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? 18'h20000 : 18'h1FFFF;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    // A left shift overflows when shifting back does not recover the operand.
    function automatic logic [DATA_W-1:0] sat_shl(input logic [DATA_W-1:0] v,
                                                  input logic [2:0]        sh);
        logic signed [DATA_W-1:0] r;
        r = $signed(v) <<< sh;
        if ((r >>> sh) != $signed(v)) begin
            return v[DATA_W-1] ? 18'h20000 : 18'h1FFFF;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/biquad_cascade_scheduler_if.sv
// Audio stream, configuration and shared-multiplier signals of the biquad
// cascade scheduler; slave is the scheduler side, master the environment side.
interface biquad_cascade_scheduler_if #(parameter int SEC_W = 3);

    logic              lr_clk;
    logic [15:0]       audio_in;
    logic [15:0]       audio_out;
    logic              out_valid;
    logic              busy;
    logic              ovr;
    logic              cfg_we;
    logic [SEC_W+2:0]  cfg_addr;
    logic [17:0]       cfg_data;
    logic              cfg_drop;
    logic [17:0]       mult_a;
    logic [17:0]       mult_b;
    logic [17:0]       mult_p;

    modport slave (
        input  lr_clk, audio_in, cfg_we, cfg_addr, cfg_data, mult_p,
        output audio_out, out_valid, busy, ovr, cfg_drop, mult_a, mult_b
    );

    modport master (
        output lr_clk, audio_in, cfg_we, cfg_addr, cfg_data, mult_p,
        input  audio_out, out_valid, busy, ovr, cfg_drop, mult_a, mult_b
    );

endinterface

// File: rtl/biquad_coef_bank.sv
// Per-section coefficient and scale register file with a one-entry pending
// write that is held while a pass runs and commits once the scheduler is idle.
module biquad_coef_bank
    import biquad_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int SEC_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idle,
    input  logic              cfg_we,
    input  logic [SEC_W+2:0]  cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              cfg_drop,
    input  logic [SEC_W-1:0]  rd_sec,
    input  logic [2:0]        rd_idx,
    output logic [COEF_W-1:0] rd_coef,
    output logic [2:0]        rd_scale
);

    localparam int DEPTH = 2 ** SEC_W;
    localparam logic [SEC_W:0] NSEC = (SEC_W + 1)'(NUM_SECTIONS);

    logic [COEF_W-1:0] coef_r [DEPTH][8];
    logic [2:0]        scale_r [DEPTH];
    logic              pend_valid_r;
    logic [SEC_W+2:0]  pend_addr_r;
    logic [COEF_W-1:0] pend_data_r;
    logic              cfg_drop_r;

    logic              addr_ok_s;
    logic              commit_s;
    logic [SEC_W+2:0]  commit_addr_s;
    logic [COEF_W-1:0] commit_data_s;
    logic              pend_load_s;
    logic              pend_clear_s;
    logic              drop_s;

    assign addr_ok_s = cfg_we && ({1'b0, cfg_addr[SEC_W+2:3]} < NSEC)
                              && (cfg_addr[2:0] <= IDX_SCALE);

    // Decide between direct commit, pending commit, pending load and drop.
    always_comb begin
        commit_s      = 1'b0;
        commit_addr_s = pend_addr_r;
        commit_data_s = pend_data_r;
        pend_load_s   = 1'b0;
        pend_clear_s  = 1'b0;
        drop_s        = 1'b0;
        if (idle) begin
            if (pend_valid_r) begin
                commit_s     = 1'b1;
                pend_load_s  = addr_ok_s;
                pend_clear_s = !addr_ok_s;
            end else if (addr_ok_s) begin
                commit_s      = 1'b1;
                commit_addr_s = cfg_addr;
                commit_data_s = cfg_data;
            end else begin
                commit_s = 1'b0;
            end
        end else begin
            if (addr_ok_s && pend_valid_r) begin
                drop_s = 1'b1;
            end else if (addr_ok_s) begin
                pend_load_s = 1'b1;
            end else begin
                drop_s = 1'b0;
            end
        end
    end

    // Register file, pending entry and drop pulse; sections reset to passthrough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int i = 0; i < 8; i++) begin
                    coef_r[s][i] <= (i == 0) ? ONE_Q216 : 18'h00000;
                end
                scale_r[s] <= 3'd0;
            end
            pend_valid_r <= 1'b0;
            pend_addr_r  <= {(SEC_W + 3){1'b0}};
            pend_data_r  <= 18'h00000;
            cfg_drop_r   <= 1'b0;
        end else begin
            cfg_drop_r <= drop_s;
            if (commit_s) begin
                if (commit_addr_s[2:0] == IDX_SCALE) begin
                    scale_r[commit_addr_s[SEC_W+2:3]] <= commit_data_s[2:0];
                end else begin
                    coef_r[commit_addr_s[SEC_W+2:3]][commit_addr_s[2:0]] <= commit_data_s;
                end
            end
            if (pend_load_s) begin
                pend_valid_r <= 1'b1;
                pend_addr_r  <= cfg_addr;
                pend_data_r  <= cfg_data;
            end else if (pend_clear_s) begin
                pend_valid_r <= 1'b0;
            end
        end
    end

    assign rd_coef  = coef_r[rd_sec][rd_idx];
    assign rd_scale = scale_r[rd_sec];
    assign cfg_drop = cfg_drop_r;

endmodule

// File: rtl/biquad_cascade_scheduler.sv
// Time-multiplexes one external 18-bit multiplier over a cascade of biquads,
// one full pass per lr_clk rising edge. Define BIQUAD_SAT_EN for saturating arithmetic.
module biquad_cascade_scheduler
    import biquad_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int SEC_W        = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    biquad_cascade_scheduler_if.slave    bus
);

    localparam int DEPTH = 2 ** SEC_W;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SECTIONS - 1);

    state_t              state_r, state_nx_s;
    logic [SEC_W-1:0]    sec_r, sec_nx_s;
    logic [2:0]          tap_r, tap_nx_s;
    logic [DATA_W-1:0]   acc_r, x_r;
    logic [DATA_W-1:0]   x_n1_r [DEPTH];
    logic [DATA_W-1:0]   x_n2_r [DEPTH];
    logic [DATA_W-1:0]   y_n1_r [DEPTH];
    logic [DATA_W-1:0]   y_n2_r [DEPTH];
    logic                lr_q_r, busy_r, ovr_r, out_valid_r;
    logic [15:0]         audio_out_r;

    logic                start_s, idle_s;
    logic [DATA_W-1:0]   acc_base_s, acc_sum_s, y_s;
    logic [COEF_W-1:0]   mult_a_s, rd_coef_s;
    logic [DATA_W-1:0]   mult_b_s;
    logic [2:0]          rd_scale_s;

    assign start_s = bus.lr_clk & ~lr_q_r;
    assign idle_s  = (state_r == ST_IDLE);

    biquad_coef_bank #(.NUM_SECTIONS(NUM_SECTIONS), .SEC_W(SEC_W)) u_coef_bank (
        .clk      (clk),
        .reset    (reset),
        .idle     (idle_s),
        .cfg_we   (bus.cfg_we),
        .cfg_addr (bus.cfg_addr),
        .cfg_data (bus.cfg_data),
        .cfg_drop (bus.cfg_drop),
        .rd_sec   (sec_r),
        .rd_idx   (tap_r),
        .rd_coef  (rd_coef_s),
        .rd_scale (rd_scale_s)
    );

    // Next-state sequencing and multiplier operand selection.
    always_comb begin
        state_nx_s = state_r;
        sec_nx_s   = sec_r;
        tap_nx_s   = tap_r;
        mult_a_s   = 18'h00000;
        mult_b_s   = 18'h00000;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_TAP;
                    sec_nx_s   = {SEC_W{1'b0}};
                    tap_nx_s   = 3'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_TAP: begin
                mult_a_s = rd_coef_s;
                case (tap_r)
                    IDX_B1:  mult_b_s = x_r;
                    IDX_B2:  mult_b_s = x_n1_r[sec_r];
                    IDX_B3:  mult_b_s = x_n2_r[sec_r];
                    IDX_A2:  mult_b_s = y_n1_r[sec_r];
                    IDX_A3:  mult_b_s = y_n2_r[sec_r];
                    default: mult_b_s = 18'h00000;
                endcase
                if (tap_r == IDX_A3) begin
                    state_nx_s = ST_WB;
                end else begin
                    tap_nx_s = tap_r + 3'd1;
                end
            end
            ST_WB: begin
                if (sec_r == LAST_SEC) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_TAP;
                    sec_nx_s   = sec_r + SEC_W'(1);
                    tap_nx_s   = 3'd0;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Accumulate and section-output scaling.
    always_comb begin
        acc_base_s = (tap_r == IDX_B1) ? 18'h00000 : acc_r;
`ifdef BIQUAD_SAT_EN
        acc_sum_s  = sat_add(acc_base_s, bus.mult_p);
        y_s        = sat_shl(acc_r, rd_scale_s);
`else
        acc_sum_s  = acc_base_s + bus.mult_p;
        y_s        = acc_r << rd_scale_s;
`endif
    end

    // FSM state, section and tap registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            sec_r   <= {SEC_W{1'b0}};
            tap_r   <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            sec_r   <= sec_nx_s;
            tap_r   <= tap_nx_s;
        end
    end

    // Datapath: sample capture, accumulation, history write-back and output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                x_n1_r[s] <= 18'h00000;
                x_n2_r[s] <= 18'h00000;
                y_n1_r[s] <= 18'h00000;
                y_n2_r[s] <= 18'h00000;
            end
            acc_r       <= 18'h00000;
            x_r         <= 18'h00000;
            lr_q_r      <= 1'b0;
            busy_r      <= 1'b0;
            ovr_r       <= 1'b0;
            out_valid_r <= 1'b0;
            audio_out_r <= 16'h0000;
        end else begin
            lr_q_r      <= bus.lr_clk;
            ovr_r       <= start_s && !idle_s;
            out_valid_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        x_r    <= {bus.audio_in, 2'b00};
                        busy_r <= 1'b1;
                    end
                end
                ST_TAP: acc_r <= acc_sum_s;
                ST_WB: begin
                    x_n2_r[sec_r] <= x_n1_r[sec_r];
                    x_n1_r[sec_r] <= x_r;
                    y_n2_r[sec_r] <= y_n1_r[sec_r];
                    y_n1_r[sec_r] <= y_s;
                    x_r           <= y_s;
                end
                ST_DONE: begin
                    audio_out_r <= x_r[DATA_W-1:2];
                    busy_r      <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mult_a    = mult_a_s;
    assign bus.mult_b    = mult_b_s;
    assign bus.audio_out = audio_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.ovr       = ovr_r;

endmodule

// File: tb/tb_biquad_cascade_scheduler.sv
// Scoreboard bench for biquad_cascade_scheduler: frames push expected samples,
// a negedge monitor pops them when out_valid fires and checks value and latency.
module tb_biquad_cascade_scheduler;

    logic clk = 1'b0;
    logic reset;

    biquad_cascade_scheduler_if #(.SEC_W(3)) bus ();

    biquad_cascade_scheduler #(.NUM_SECTIONS(4), .SEC_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External signed multiplier: full 36-bit product reduced to {sign, [32:16]}.
    logic signed [35:0] full_s;
    assign full_s     = $signed(bus.mult_a) * $signed(bus.mult_b);
    assign bus.mult_p = {full_s[35], full_s[32:16]};

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   ovr_cnt = 0;
    int   drop_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every out_valid against the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.ovr) ovr_cnt++;
            if (bus.cfg_drop) drop_cnt++;
            if (bus.out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got %h at cycle %0d, none expected", bus.audio_out, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.audio_out !== mon_e.data || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL audio_out got %h at cycle %0d, expected %h at cycle %0d",
                                 bus.audio_out, cyc, mon_e.data, mon_e.due);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cfg_write(input int s, input int idx, input logic [17:0] d);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'(s * 8 + idx);
        bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic frame(input logic [15:0] s, input logic [15:0] exp);
        @(negedge clk);
        bus.lr_clk   = 1'b1;
        bus.audio_in = s;
        sb.push_back('{data: exp, due: cyc + 26});
        repeat (3) @(negedge clk);
        bus.lr_clk = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        bus.lr_clk   = 1'b0;
        bus.audio_in = 16'h0000;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = 6'd0;
        bus.cfg_data = 18'h00000;
        repeat (3) @(negedge clk);
        check("rst_audio_out", 32'(bus.audio_out), 32'h0);
        check("rst_flags", {28'h0, bus.out_valid, bus.busy, bus.ovr, bus.cfg_drop}, 32'h0);
        check("rst_mult_ops", {bus.mult_a[15:0], bus.mult_b[15:0]}, 32'h0);
        reset = 1'b1;

        // Passthrough defaults, positive and negative samples.
        frame(16'h1234, 16'h1234);
        frame(16'hC000, 16'hC000);

        // Section 0 gain of one half, impulse then silence.
        cfg_write(0, 0, 18'h08000);
        frame(16'h4000, 16'h2000);
        for (int i = 0; i < 3; i++) frame(16'h0000, 16'h0000);

        // First-order recursion y = x + 0.5*y[n-1].
        cfg_write(0, 0, 18'h10000);
        cfg_write(0, 3, 18'h08000);
        frame(16'h4000, 16'h4000);
        frame(16'h0000, 16'h2000);
        frame(16'h0000, 16'h1000);
        frame(16'h0000, 16'h0800);
        cfg_write(0, 3, 18'h00000);

        // Overrun: second edge mid-pass is flagged and its sample never captured.
        @(negedge clk);
        bus.lr_clk   = 1'b1;
        bus.audio_in = 16'h1111;
        sb.push_back('{data: 16'h1111, due: cyc + 26});
        repeat (3) @(negedge clk);
        bus.lr_clk = 1'b0;
        repeat (6) @(negedge clk);
        bus.lr_clk   = 1'b1;
        bus.audio_in = 16'h5555;
        repeat (2) @(negedge clk);
        check("busy_mid_pass", 32'(bus.busy), 32'h1);
        bus.lr_clk = 1'b0;
        repeat (25) @(negedge clk);
        check("ovr_count", ovr_cnt, 32'd1);
        frame(16'h2222, 16'h2222);

        // Two writes during a pass: first pends and commits, second is dropped.
        @(negedge clk);
        bus.lr_clk   = 1'b1;
        bus.audio_in = 16'h0400;
        sb.push_back('{data: 16'h0400, due: cyc + 26});
        repeat (3) @(negedge clk);
        bus.lr_clk = 1'b0;
        cfg_write(0, 0, 18'h08000);
        cfg_write(0, 5, 18'h00001);
        repeat (30) @(negedge clk);
        check("drop_count", drop_cnt, 32'd1);
        frame(16'h0400, 16'h0200);

        // Write coinciding with start is used by that pass.
        @(negedge clk);
        bus.lr_clk   = 1'b1;
        bus.audio_in = 16'h0600;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'd0;
        bus.cfg_data = 18'h10000;
        sb.push_back('{data: 16'h0600, due: cyc + 26});
        @(negedge clk);
        bus.cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        bus.lr_clk = 1'b0;
        repeat (30) @(negedge clk);

        // Out-of-range section and idx 6 writes are silently ignored.
        cfg_write(5, 0, 18'h00000);
        cfg_write(0, 6, 18'h00000);
        frame(16'h0700, 16'h0700);
        check("drop_after_ignored", drop_cnt, 32'd1);

        // Section 1 scale of one doubles the output.
        cfg_write(1, 5, 18'h00001);
        frame(16'h0100, 16'h0200);

        // Reset mid-pass abandons the pass and restores passthrough.
        @(negedge clk);
        bus.lr_clk   = 1'b1;
        bus.audio_in = 16'h7777;
        repeat (12) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_audio_out", 32'(bus.audio_out), 32'h0);
        check("midrst_flags", {29'h0, bus.out_valid, bus.busy, bus.ovr}, 32'h0);
        check("midrst_mult_ops", {bus.mult_a[15:0], bus.mult_b[15:0]}, 32'h0);
        bus.lr_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        frame(16'h7FFF, 16'h7FFF);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
